// File: rtl/calc_key_entry.sv
// calc_key_entry
// Keypad front-end for the combinational calculator. Decimal keys build two
// signed operands (sign + magnitude, up to MAX_DIGITS digits each). The
// operands and the operation code are held in registers that feed the
// calculator. On "equals" the calculator result is captured one cycle later.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   key_valid      key_code is valid this cycle
//   key_code       0-9 digit, 10-14 add/sub/mul/div/pow, 15 equals,
//                  16 clear, 17 negate, 18-31 accepted and ignored
//   key_ready      low only during the single capture cycle
//   a, b           signed operands to the calculator (registered)
//   operand        operation code to the calculator (registered)
//   result         combinational result from the calculator
//   result_out     captured result (0 when the result had X/Z bits)
//   result_valid   one-cycle pulse when result_out updates
//   error          last capture saw an X/Z result
//   digit_count    digits entered into the operand being edited
module calc_key_entry #(
    parameter int nb         = 64,
    parameter int MAX_DIGITS = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [4:0]    key_code,
    output logic          key_ready,
    output logic [nb-1:0] a,
    output logic [nb-1:0] b,
    output logic [2:0]    operand,
    input  logic [nb-1:0] result,
    output logic [nb-1:0] result_out,
    output logic          result_valid,
    output logic          error,
    output logic [3:0]    digit_count
);

    typedef enum logic [1:0] {S_A, S_B, S_EVAL, S_SHOW} state_t;

    state_t        state;
    logic [nb-1:0] a_mag, b_mag;
    logic          a_neg, b_neg;

    // Key decode
    logic          is_digit, is_op, is_eq, is_clr, is_neg;
    logic [2:0]    op_code;
    logic [nb-1:0] digit;
    logic [nb-1:0] a_mag_dig, b_mag_dig;
    logic          room;
    logic [nb-1:0] res_mag;

    always_comb begin
        is_digit = (key_code < 5'd10);
        is_op    = (key_code >= 5'd10) && (key_code <= 5'd14);
        is_eq    = (key_code == 5'd15);
        is_clr   = (key_code == 5'd16);
        is_neg   = (key_code == 5'd17);
        op_code  = 3'd0;
        case (key_code)
            5'd11:   op_code = 3'd1;
            5'd12:   op_code = 3'd2;
            5'd13:   op_code = 3'd3;
            5'd14:   op_code = 3'd4;
            default: op_code = 3'd0;
        endcase
    end

    assign digit     = {{(nb-4){1'b0}}, key_code[3:0]};
    // mag*10 + d done at nb bits as shift-and-add
    assign a_mag_dig = (a_mag << 3) + (a_mag << 1) + digit;
    assign b_mag_dig = (b_mag << 3) + (b_mag << 1) + digit;
    assign room      = (digit_count < 4'(MAX_DIGITS));
    // Sign/magnitude split of the shown result for chaining
    assign res_mag   = result_out[nb-1] ? -result_out : result_out;

    function automatic logic [nb-1:0] sval(input logic [nb-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_A;
            a_mag        <= '0;
            a_neg        <= 1'b0;
            b_mag        <= '0;
            b_neg        <= 1'b0;
            a            <= '0;
            b            <= '0;
            operand      <= 3'd0;
            digit_count  <= 4'd0;
            result_out   <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            key_ready    <= 1'b1;
        end else begin
            result_valid <= 1'b0;
            if (state == S_EVAL) begin
                if ($isunknown(result)) begin
                    error      <= 1'b1;
                    result_out <= '0;
                end else begin
                    error      <= 1'b0;
                    result_out <= result;
                end
                result_valid <= 1'b1;
                key_ready    <= 1'b1;
                state        <= S_SHOW;
            end else if (key_valid) begin
                if (is_clr) begin
                    a_mag       <= '0;
                    a_neg       <= 1'b0;
                    b_mag       <= '0;
                    b_neg       <= 1'b0;
                    a           <= '0;
                    b           <= '0;
                    operand     <= 3'd0;
                    digit_count <= 4'd0;
                    result_out  <= '0;
                    error       <= 1'b0;
                    state       <= S_A;
                end else begin
                    case (state)
                        S_A: begin
                            if (is_digit && room) begin
                                a_mag       <= a_mag_dig;
                                a           <= sval(a_mag_dig, a_neg);
                                digit_count <= digit_count + 4'd1;
                            end else if (is_neg) begin
                                a_neg <= ~a_neg;
                                a     <= sval(a_mag, ~a_neg);
                            end else if (is_op) begin
                                operand     <= op_code;
                                b_mag       <= '0;
                                b_neg       <= 1'b0;
                                b           <= '0;
                                digit_count <= 4'd0;
                                state       <= S_B;
                            end
                        end
                        S_B: begin
                            if (is_digit && room) begin
                                b_mag       <= b_mag_dig;
                                b           <= sval(b_mag_dig, b_neg);
                                digit_count <= digit_count + 4'd1;
                            end else if (is_neg) begin
                                b_neg <= ~b_neg;
                                b     <= sval(b_mag, ~b_neg);
                            end else if (is_op && digit_count == 4'd0) begin
                                operand <= op_code;
                            end else if (is_eq) begin
                                key_ready <= 1'b0;
                                state     <= S_EVAL;
                            end
                        end
                        S_SHOW: begin
                            if (is_digit) begin
                                a_mag       <= digit;
                                a_neg       <= 1'b0;
                                a           <= digit;
                                b_mag       <= '0;
                                b_neg       <= 1'b0;
                                b           <= '0;
                                digit_count <= 4'd1;
                                error       <= 1'b0;
                                state       <= S_A;
                            end else if (is_op && !error) begin
                                a_mag       <= res_mag;
                                a_neg       <= result_out[nb-1];
                                a           <= result_out;
                                operand     <= op_code;
                                b_mag       <= '0;
                                b_neg       <= 1'b0;
                                b           <= '0;
                                digit_count <= 4'd0;
                                state       <= S_B;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_key_entry.sv
module tb_calc_key_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = 5'd0;
    logic        key_ready;
    logic [63:0] a, b, result, result_out;
    logic [2:0]  operand;
    logic        result_valid, error;
    logic [3:0]  digit_count;

    int n_chk = 0;
    int n_err = 0;

    calc_key_entry #(.nb(64), .MAX_DIGITS(12)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .a(a), .b(b), .operand(operand),
        .result(result), .result_out(result_out), .result_valid(result_valid),
        .error(error), .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    // Behavioural calculator: divide by zero yields an all-X result
    function automatic logic [63:0] calc_fn(input logic [63:0] x, input logic [63:0] y,
                                            input logic [2:0] op);
        longint sx, sy, p, base;
        longint unsigned e;
        sx = x;
        sy = y;
        case (op)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x * y;
            3'd3: begin
                if (sy == 0) return 'x;
                return 64'(sx / sy);
            end
            3'd4: begin
                if (sy < 0) return 64'd0;
                p = 1;
                base = sx;
                e = sy;
                while (e != 0) begin
                    if (e[0]) p = p * base;
                    base = base * base;
                    e = e >> 1;
                end
                return 64'(p);
            end
            default: return 64'd0;
        endcase
    endfunction

    always_comb result = calc_fn(a, b, operand);

    // Reference model: operands as sign + magnitude integers
    localparam int M_A = 0, M_B = 1, M_EV = 2, M_SH = 3;
    typedef struct { logic [63:0] res; bit err; } exp_t;
    exp_t exp_q[$];

    longint unsigned m_amag, m_bmag;
    bit              m_aneg, m_bneg, m_err;
    int              m_op, m_cnt, m_mode;
    logic [63:0]     m_res;

    function automatic logic [63:0] sv(input longint unsigned m, input bit n);
        return n ? 64'(-m) : 64'(m);
    endfunction

    task automatic model_reset();
        m_amag = 0; m_bmag = 0; m_aneg = 0; m_bneg = 0;
        m_op = 0; m_cnt = 0; m_res = 0; m_err = 0; m_mode = M_A;
    endtask

    task automatic model_step(input bit v, input int k);
        logic [63:0] r;
        exp_t e;
        if (m_mode == M_EV) begin
            r = calc_fn(sv(m_amag, m_aneg), sv(m_bmag, m_bneg), 3'(m_op));
            m_err = $isunknown(r);
            m_res = m_err ? 64'd0 : r;
            e.res = m_res;
            e.err = m_err;
            exp_q.push_back(e);
            m_mode = M_SH;
            return;
        end
        if (!v) return;
        if (k == 16) begin
            model_reset();
        end else if (k <= 9) begin
            if (m_mode == M_SH) begin
                m_amag = k; m_aneg = 0; m_cnt = 1; m_bmag = 0; m_bneg = 0;
                m_err = 0; m_mode = M_A;
            end else if (m_cnt < 12) begin
                if (m_mode == M_A) m_amag = m_amag * 10 + k;
                else               m_bmag = m_bmag * 10 + k;
                m_cnt++;
            end
        end else if (k <= 14) begin
            if (m_mode == M_A || (m_mode == M_SH && !m_err)) begin
                if (m_mode == M_SH) begin
                    m_aneg = m_res[63];
                    m_amag = m_aneg ? -m_res : m_res;
                end
                m_op = k - 10; m_bmag = 0; m_bneg = 0; m_cnt = 0; m_mode = M_B;
            end else if (m_mode == M_B && m_cnt == 0) begin
                m_op = k - 10;
            end
        end else if (k == 15) begin
            if (m_mode == M_B) m_mode = M_EV;
        end else if (k == 17) begin
            if (m_mode == M_A) m_aneg = !m_aneg;
            if (m_mode == M_B) m_bneg = !m_bneg;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // One clock cycle: drive at negedge, step model at posedge, check after it
    task automatic cycle(input bit v, input int k);
        bit acc;
        @(negedge clk);
        key_valid = v;
        key_code  = 5'(k);
        chk("key_ready", 64'(key_ready), 64'(m_mode != M_EV));
        acc = v && (m_mode != M_EV);
        @(posedge clk);
        model_step(acc, k);
        #1;
        chk("a", a, sv(m_amag, m_aneg));
        chk("b", b, sv(m_bmag, m_bneg));
        chk("operand", 64'(operand), 64'(m_op));
        chk("digit_count", 64'(digit_count), 64'(m_cnt));
    endtask

    task automatic idle2();
        cycle(0, 0);
        cycle(0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key_valid = 1'b0;
        #1;
        model_reset();
        chk("rst a", a, 64'd0);
        chk("rst b", b, 64'd0);
        chk("rst result_out", result_out, 64'd0);
        chk("rst operand", 64'(operand), 64'd0);
        chk("rst digit_count", 64'(digit_count), 64'd0);
        chk("rst result_valid", 64'(result_valid), 64'd0);
        chk("rst error", 64'(error), 64'd0);
        chk("rst key_ready", 64'(key_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every result_valid pulse must match the oldest expectation
    initial begin
        bit prev_rv = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rv = 0;
            end else begin
                if (result_valid) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL result_valid: got unexpected pulse, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_out", result_out, e.res);
                        chk("error", 64'(error), 64'(e.err));
                    end
                end
                if (result_valid && prev_rv) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rv_pulse: got 2 consecutive cycles, expected 1");
                end
                prev_rv = result_valid;
            end
        end
    end

    initial begin
        int r, k;
        model_reset();
        do_reset();

        // 12 + 34
        cycle(1, 1); cycle(1, 2); cycle(1, 10); cycle(1, 3); cycle(1, 4); cycle(1, 15);
        idle2();
        chk("sum literal", result_out, 64'd46);

        // -5 * 7, then chained - 5
        cycle(1, 16);
        cycle(1, 5); cycle(1, 17); cycle(1, 12); cycle(1, 7); cycle(1, 15);
        idle2();
        cycle(1, 11); cycle(1, 5); cycle(1, 15);
        idle2();
        chk("chain literal", result_out, 64'hFFFF_FFFF_FFFF_FFD8);

        // Thirteen nines: last one ignored
        cycle(1, 16);
        for (int i = 0; i < 13; i++) cycle(1, 9);
        chk("max digits a", a, 64'd999999999999);
        chk("max digits cnt", 64'(digit_count), 64'd12);

        // Divide by zero, then add (ignored on error), then new digit
        cycle(1, 16);
        cycle(1, 8); cycle(1, 13); cycle(1, 0); cycle(1, 15);
        idle2();
        cycle(1, 10); cycle(1, 3);

        // Operator replacement with no B digits; ignored once B has digits
        cycle(1, 16);
        cycle(1, 4); cycle(1, 10); cycle(1, 11); cycle(1, 2); cycle(1, 15);
        idle2();
        cycle(1, 16);
        cycle(1, 4); cycle(1, 10); cycle(1, 2); cycle(1, 12);
        chk("op kept", 64'(operand), 64'd0);

        // Key during capture cycle is dropped; ignored codes
        cycle(1, 15); cycle(1, 7); cycle(1, 20); cycle(1, 31);
        idle2();

        // Reset in the capture cycle: no pulse
        cycle(1, 16);
        cycle(1, 6); cycle(1, 10); cycle(1, 6); cycle(1, 15);
        do_reset();
        idle2();

        // Random keys
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      k = $urandom_range(0, 9);
            else if (r < 60) k = $urandom_range(10, 14);
            else if (r < 72) k = 15;
            else if (r < 79) k = 17;
            else if (r < 82) k = 16;
            else if (r < 88) k = $urandom_range(18, 31);
            else             k = -1;
            if (k < 0) cycle(0, 0);
            else       cycle(1, k);
        end
        idle2();

        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending: got %0d outstanding results, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
